// File: rtl/div_pkg.sv
// Shared divider types: operand/tag widths and the packed result record
// carried from the divider wrapper into the completion buffer.
package div_pkg;

  localparam int unsigned DIV_DATA_W = 64;
  localparam int unsigned DIV_USR_W  = 5;

  typedef struct packed {
    logic [DIV_DATA_W-1:0] quotient;
    logic [DIV_DATA_W-1:0] remainder;
    logic [DIV_USR_W-1:0]  usr;
    logic                  div_by_zero;
  } div_result_t;

  localparam int unsigned DIV_RESULT_W = $bits(div_result_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: flop array with registered write and asynchronous head read.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    do_rd      = rd_en && !empty;
    do_wr      = wr_en && (!full || do_rd);
    count_next = count + CW'(do_wr) - CW'(do_rd);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/div64_result_buf.sv
// Completion buffer behind the pipelined divider: queues result pulses in order,
// hands them out over valid/ready and raises stop early enough to absorb in-flight results.
module div64_result_buf
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned USR_W  = DIV_USR_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SKID   = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_en,
  input  logic [DATA_W-1:0] io_in_quotient,
  input  logic [DATA_W-1:0] io_in_remainder,
  input  logic [USR_W-1:0]  io_in_usr,
  input  logic              io_in_div_by_zero,
  output logic              io_stop,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_quotient,
  output logic [DATA_W-1:0] io_out_remainder,
  output logic [USR_W-1:0]  io_out_usr,
  output logic              io_out_div_by_zero,
  output logic [CW-1:0]     io_count,
  output logic              io_overflow
);

  localparam logic [CW-1:0] STOP_AT = CW'(DEPTH - SKID);

  div_result_t     in_word;
  div_result_t     head_word;
  logic [CW-1:0]   count_next;
  logic            full;
  logic            empty;
  logic            deq;
  logic            drop;

  always_comb begin
    in_word.quotient    = DIV_DATA_W'(io_in_quotient);
    in_word.remainder   = DIV_DATA_W'(io_in_remainder);
    in_word.usr         = DIV_USR_W'(io_in_usr);
    in_word.div_by_zero = io_in_div_by_zero;
  end

  sync_fifo #(
    .WIDTH (DIV_RESULT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (io_in_en),
    .wr_data    (in_word),
    .rd_en      (io_out_ready),
    .rd_data    (head_word),
    .count      (io_count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  assign io_out_valid = !empty;
  assign deq          = io_out_valid && io_out_ready;
  assign drop         = io_in_en && full && !deq;

  // Head fields read as zero while the buffer is empty (including after reset).
  always_comb begin
    io_out_quotient    = '0;
    io_out_remainder   = '0;
    io_out_usr         = '0;
    io_out_div_by_zero = 1'b0;
    if (io_out_valid) begin
      io_out_quotient    = DATA_W'(head_word.quotient);
      io_out_remainder   = DATA_W'(head_word.remainder);
      io_out_usr         = USR_W'(head_word.usr);
      io_out_div_by_zero = head_word.div_by_zero;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_stop     <= 1'b0;
      io_overflow <= 1'b0;
    end else begin
      io_stop <= (count_next >= STOP_AT);
      if (drop) io_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div64_result_buf.sv
// Directed and randomised checks of the divider completion buffer.
module tb_div64_result_buf;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_en;
  logic [63:0] io_in_quotient;
  logic [63:0] io_in_remainder;
  logic [4:0]  io_in_usr;
  logic        io_in_div_by_zero;
  logic        io_stop;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_quotient;
  logic [63:0] io_out_remainder;
  logic [4:0]  io_out_usr;
  logic        io_out_div_by_zero;
  logic [3:0]  io_count;
  logic        io_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  div64_result_buf dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_en           (io_in_en),
    .io_in_quotient     (io_in_quotient),
    .io_in_remainder    (io_in_remainder),
    .io_in_usr          (io_in_usr),
    .io_in_div_by_zero  (io_in_div_by_zero),
    .io_stop            (io_stop),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_quotient    (io_out_quotient),
    .io_out_remainder   (io_out_remainder),
    .io_out_usr         (io_out_usr),
    .io_out_div_by_zero (io_out_div_by_zero),
    .io_count           (io_count),
    .io_overflow        (io_overflow)
  );

  typedef struct {
    logic        en;
    logic [63:0] q;
    logic [63:0] r;
    logic [4:0]  usr;
    logic        dbz;
    logic        rdy;
    logic        ev;
    logic [3:0]  ecnt;
    logic        estop;
    logic        eovf;
    logic [63:0] eq;
    logic [63:0] er;
    logic [4:0]  eusr;
    logic        edbz;
  } vec_t;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic [4:0]  usr;
    logic        dbz;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [63:0] q, input logic [63:0] r,
                       input logic [4:0] usr, input logic dbz, input logic rdy);
    io_in_en          = en;
    io_in_quotient    = q;
    io_in_remainder   = r;
    io_in_usr         = usr;
    io_in_div_by_zero = dbz;
    io_out_ready      = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic en, input logic [63:0] q, input logic [63:0] r,
                              input logic [4:0] usr, input logic dbz, input logic rdy,
                              input logic ev, input logic [3:0] ecnt, input logic estop,
                              input logic eovf, input logic [63:0] eq, input logic [63:0] er,
                              input logic [4:0] eusr, input logic edbz);
    vec_t v;
    v.en = en; v.q = q; v.r = r; v.usr = usr; v.dbz = dbz; v.rdy = rdy;
    v.ev = ev; v.ecnt = ecnt; v.estop = estop; v.eovf = eovf;
    v.eq = eq; v.er = er; v.eusr = eusr; v.edbz = edbz;
    return v;
  endfunction

  initial begin
    logic        pend_v;
    exp_t        pend;
    logic [4:0]  tag;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;

    do_reset();
    chk("reset_valid", io_out_valid, 0);
    chk("reset_count", io_count, 0);
    chk("reset_stop", io_stop, 0);
    chk("reset_ovf", io_overflow, 0);
    chk("reset_q", io_out_quotient, 0);

    // Single result, then threshold crossing with ready low, then release.
    vecs.push_back(mk(1, 64'h5, 64'h3, 5'h1A, 0, 1,  1, 1, 0, 0, 64'h5, 64'h3, 5'h1A, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk(1, 64'h10 + 64'(k), 64'h20 + 64'(k), 5'(k), 0, 0,
                        1, 4'(k), (k == 6), 0, 64'h11, 64'h21, 5'h1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,               1, 5, 0, 0, 64'h12, 64'h22, 5'h2, 0));
    vecs.push_back(mk(1, 64'h30, 64'h31, 5'h1F, 1, 0, 1, 6, 1, 0, 64'h12, 64'h22, 5'h2, 0));
    vecs.push_back(mk(1, 64'h40, 64'h41, 5'h0, 0, 1,  1, 6, 1, 0, 64'h13, 64'h23, 5'h3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].q, vecs[i].r, vecs[i].usr, vecs[i].dbz, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_valid", i), io_out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_count", i), io_count, vecs[i].ecnt);
      chk($sformatf("vec%0d_stop", i), io_stop, vecs[i].estop);
      chk($sformatf("vec%0d_ovf", i), io_overflow, vecs[i].eovf);
      chk($sformatf("vec%0d_q", i), io_out_quotient, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), io_out_remainder, vecs[i].er);
      chk($sformatf("vec%0d_usr", i), io_out_usr, vecs[i].eusr);
      chk($sformatf("vec%0d_dbz", i), io_out_div_by_zero, vecs[i].edbz);
    end

    // Overflow: nine writes into an eight-deep buffer drop the ninth.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 64'd100 + 64'(i), 64'(i), 5'(i), 0, 0);
      step();
      if (i == 8) chk("ovf_before_ninth", io_overflow, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_count", io_count, 8);
    chk("ovf_set", io_overflow, 1);
    chk("ovf_stop", io_stop, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), io_out_valid, 1);
      chk($sformatf("ovf_drain%0d_q", i), io_out_quotient, 64'd100 + 64'(i));
      chk($sformatf("ovf_drain%0d_usr", i), io_out_usr, 5'(i));
      io_out_ready = 1'b1;
      step();
    end
    chk("ovf_empty_valid", io_out_valid, 0);
    chk("ovf_empty_count", io_count, 0);
    chk("ovf_sticky", io_overflow, 1);
    chk("ovf_stop_released", io_stop, 0);

    // Simultaneous enqueue and dequeue while full.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 64'd200 + 64'(i), 0, 5'(i), 0, 0);
      step();
    end
    drive(1, 64'd209, 0, 5'd9, 0, 1);
    step();
    chk("simfull_count", io_count, 8);
    chk("simfull_ovf", io_overflow, 0);
    chk("simfull_head", io_out_quotient, 64'd202);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("simfull_drain%0d_q", i), io_out_quotient, 64'd200 + 64'(i));
      step();
    end
    chk("simfull_empty", io_out_valid, 0);

    // Divide-by-zero passes through; reset mid-operation flushes.
    do_reset();
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 5'h07, 1, 0);
    step();
    chk("dbz_flag", io_out_div_by_zero, 1);
    chk("dbz_q", io_out_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dbz_r", io_out_remainder, 64'h1234_5678_9ABC_DEF0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(i), 0, 5'(i), 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("prerst_count", io_count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_valid", io_out_valid, 0);
    chk("rst_count", io_count, 0);
    chk("rst_stop", io_stop, 0);
    chk("rst_ovf", io_overflow, 0);
    chk("rst_q", io_out_quotient, 0);

    // Random results from a one-stage divider model that honours stop, random ready.
    do_reset();
    pend_v = 1'b0;
    pend   = '0;
    tag    = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      io_out_ready = rdy;
      if (io_out_valid && rdy) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected_valid", 1, 0);
        end else begin
          chk("rand_q", io_out_quotient, sb[0].q);
          chk("rand_r", io_out_remainder, sb[0].r);
          chk("rand_usr", io_out_usr, sb[0].usr);
          chk("rand_dbz", io_out_div_by_zero, sb[0].dbz);
          void'(sb.pop_front());
        end
      end
      io_in_en          = pend_v;
      io_in_quotient    = pend.q;
      io_in_remainder   = pend.r;
      io_in_usr         = pend.usr;
      io_in_div_by_zero = pend.dbz;
      if (pend_v) sb.push_back(pend);
      pend_v = !io_stop && ($urandom_range(0, 3) != 0);
      if (pend_v) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} >> $urandom_range(0, 63);
        if ($urandom_range(0, 31) == 0) b = '0;
        pend.dbz = (b == '0);
        pend.q   = (b == '0) ? '1 : a / b;
        pend.r   = (b == '0) ? a : a % b;
        pend.usr = tag;
        tag      = tag + 5'd1;
      end
      step();
    end
    io_in_en     = pend_v;
    io_in_quotient    = pend.q;
    io_in_remainder   = pend.r;
    io_in_usr         = pend.usr;
    io_in_div_by_zero = pend.dbz;
    if (pend_v) sb.push_back(pend);
    io_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (io_out_valid) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_valid", 1, 0);
        end else begin
          chk("drain_q", io_out_quotient, sb[0].q);
          chk("drain_r", io_out_remainder, sb[0].r);
          chk("drain_usr", io_out_usr, sb[0].usr);
          void'(sb.pop_front());
        end
      end
      step();
      io_in_en = 1'b0;
    end
    chk("rand_leftover", 64'(sb.size()), 0);
    chk("rand_final_count", io_count, 0);
    chk("rand_ovf", io_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div64_result_buf.md
Name: div64_result_buf

Overview:
- Downstream completion buffer for the 64-bit pipelined divider with the 5-bit user tag.
- Captures every divider result pulse (quotient, remainder, user tag, div-by-zero flag) into an in-order FIFO.
- Delivers the results to the consumer over a valid/ready handshake.
- Drives the divider's stop input as backpressure, so results still in flight after stop is raised are never lost.

Parameters:
- DATA_W, 64, quotient/remainder width.
- USR_W, 5, user tag width.
- DEPTH, 8, FIFO entries; power of two, >= 4.
- SKID, 2, entries kept free for in-flight results once stop is raised; 1 <= SKID < DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- io_in_en  in  1  divider result valid pulse.
- io_in_quotient  in  DATA_W  divider quotient.
- io_in_remainder  in  DATA_W  divider remainder.
- io_in_usr  in  USR_W  divider user tag.
- io_in_div_by_zero  in  1  divider divide-by-zero flag.
- io_stop  out  1  backpressure to the divider's stop input.
- io_out_valid  out  1  head entry valid.
- io_out_ready  in  1  consumer accepts head.
- io_out_quotient  out  DATA_W  head quotient.
- io_out_remainder  out  DATA_W  head remainder.
- io_out_usr  out  USR_W  head user tag.
- io_out_div_by_zero  out  1  head divide-by-zero flag.
- io_count  out  log2(DEPTH)+1  current occupancy.
- io_overflow  out  1  sticky; a result was dropped.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high, sampled on the rising edge of clock.
  - During and after reset: count=0, rd/wr pointers=0, io_out_valid=0, io_stop=0, io_overflow=0, io_out_* data=0, io_count=0.
- Reset mid-operation flushes all entries. Contents are discarded and not drained.
- Enqueue:
  - Occurs when io_in_en=1 and (count<DEPTH or a dequeue happens in the same cycle).
  - Entry written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Dequeue:
  - Occurs when io_out_valid=1 and io_out_ready=1.
  - rd_ptr advances and wraps modulo DEPTH.
- Output timing:
  - io_out_valid = (count!=0).
  - io_out_* = entry at rd_ptr.
  - No write-through bypass: an entry written into an empty buffer becomes visible the cycle after io_in_en (1-cycle latency).
- io_out_* data must hold stable while io_out_valid=1 and io_out_ready=0.
- Ordering: strict FIFO. The user tag is carried, never interpreted or reordered.
- Count update:
  - count_next = count + enq - deq.
  - Simultaneous enq+deq leaves count unchanged, including at full and at count=1.
- Backpressure:
  - io_stop is a register, loaded with (count_next >= DEPTH-SKID).
  - It is therefore asserted the cycle after the enqueue that reaches the threshold.
  - It is deasserted the cycle after the dequeue that brings count_next below the threshold.
- Overflow:
  - io_in_en=1 while count==DEPTH and no dequeue that cycle drops the result.
  - Pointers and count are unchanged.
  - io_overflow is set the next cycle and held until reset.
- io_in_en=1 with io_in_div_by_zero=1 is stored like any other result. Quotient/remainder pass through unmodified.
- Storage: flop array or inferred RAM with a registered write and an asynchronous head read.

Decomposition:
- Shared package div_pkg holds:
  - DIV_DATA_W=64 and DIV_USR_W=5.
  - Typedef div_result_t, a packed struct {quotient, remainder, usr, div_by_zero}, used by the divider wrapper and this buffer.
- One natural sub-module: sync_fifo (parameterised width/depth), with count, full and empty outputs.
- div64_result_buf adds the stop threshold register, the overflow sticky bit and the struct pack/unpack.

Test Plan:
- Single result: io_in_en pulse, q=0x5, r=0x3, usr=0x1A, ready=1 -> the next cycle shows valid=1 with identical fields; it is dequeued that cycle and count returns to 0.
- Threshold: ready=0, 6 back-to-back writes (DEPTH=8, SKID=2) -> io_stop=1 on the cycle after the 6th write, and not earlier. Raise ready for 1 cycle -> io_stop=0 the cycle after the dequeue.
- Full/overflow: ready=0, 9 writes -> count=8 and io_overflow=1 after the 9th. Draining yields exactly entries 1..8 in order; the 9th is absent. io_overflow stays 1.
- Simultaneous at full: count=8, ready=1, io_in_en=1 -> count stays 8, io_overflow stays 0, head advances, new entry lands last.
- Divide-by-zero and reset: enqueue with div_by_zero=1 and check it propagates. Then assert reset with count=5 -> the next cycle has valid=0, count=0, stop=0, overflow=0.
- Integrated: chain the divider and this buffer, 1000 random 64-bit operand pairs, random ready -> every output equals in1/in2 and in1%in2 in issue order with the matching usr, and overflow stays 0.
